seg_scan_driver: RTL

Multiplexed 7-segment display driver; the encoding counterpart to the segment-to-hex decoder. It takes DIGITS hex nibbles plus decimal-point flags and time-multiplexes them onto one shared 8-bit segment bus with one-hot digit enables. Updates are double-buffered, so a new value appears only at a frame boundary and the display never tears. It sits between register/counter logic and the board display pins.

---
 rtl/seg_scan_driver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: double-buffered hex digits, one-hot anodes,
// optional leading-zero blanking, registered outputs one cycle behind the scan index.
module seg_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   hex_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_tick
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] CNT_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

   function automatic logic [6:0] enc(input logic [3:0] nib);
      case (nib)
         4'h0: enc = 7'h3F;  4'h1: enc = 7'h06;  4'h2: enc = 7'h5B;  4'h3: enc = 7'h4F;
         4'h4: enc = 7'h66;  4'h5: enc = 7'h6D;  4'h6: enc = 7'h7D;  4'h7: enc = 7'h07;
         4'h8: enc = 7'h7F;  4'h9: enc = 7'h6F;  4'hA: enc = 7'h77;  4'hB: enc = 7'h7C;
         4'hC: enc = 7'h39;  4'hD: enc = 7'h5E;  4'hE: enc = 7'h79;  default: enc = 7'h71;
      endcase
   endfunction

   logic [PW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow_hex, disp_hex;
   logic [DIGITS-1:0]   shadow_dp, disp_dp;
   logic                pending;

   logic                tick, wrap;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;
   logic                run_zero;

   assign tick = en && (cnt == CNT_MAX);
   assign wrap = tick && (idx == IDX_MAX);

   // Select the active display digit and decide whether it is a leading zero.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      run_zero  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (i == 0) begin
            run_zero = 1'b0;
         end else begin
            run_zero = run_zero && (disp_hex[4*i +: 4] == 4'h0) && !disp_dp[i];
         end
         if (idx == IW'(i)) begin
            cur_nib   = disp_hex[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_blank = blank_lz && run_zero;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (!en) begin
         cnt <= '0;
         idx <= '0;
      end else if (tick) begin
         cnt <= '0;
         idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shadow/display double buffer: commits only on a frame wrap while scanning.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_hex <= '0;
         shadow_dp  <= '0;
         disp_hex   <= '0;
         disp_dp    <= '0;
         pending    <= 1'b0;
      end else if (!en) begin
         if (load) begin
            shadow_hex <= hex_in;
            shadow_dp  <= dp_in;
            disp_hex   <= hex_in;
            disp_dp    <= dp_in;
         end
         pending <= 1'b0;
      end else begin
         if (wrap && pending) begin
            disp_hex <= shadow_hex;
            disp_dp  <= shadow_dp;
         end
         if (load) begin
            shadow_hex <= hex_in;
            shadow_dp  <= dp_in;
            pending    <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out    <= '0;
         an_out     <= '0;
         frame_tick <= 1'b0;
      end else if (!en) begin
         seg_out    <= '0;
         an_out     <= '0;
         frame_tick <= 1'b0;
      end else begin
         an_out     <= DIGITS'(1) << idx;
         seg_out    <= cur_blank ? 8'h00 : {cur_dp, enc(cur_nib)};
         frame_tick <= wrap;
      end
   end

endmodule
